accreg8bit: RTL and testbench
=============================

Name: accreg8bit

Overview:
- Clocked 8-bit accumulator register, default width 8.
- Each enabled clock edge either loads the input word or adds it to the stored value.
- Used as the accumulator (ACC) storage/adder element of a simple datapath.
- Output is the registered accumulator value.

Parameters:
- WIDTH, 8, data and accumulator width in bits (must be >= 1).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset; clears the accumulator.
- D  input  WIDTH  operand: load value or addend.
- en  input  1  clock enable; when 0 the register holds.
- ldacc  input  1  mode select: 1 = load D, 0 = accumulate Q + D.
- Q  output  WIDTH  current accumulator contents (registered).

Behaviour:
- Interface rules:
  - One clock.
  - Reset is asynchronous and active-low.
  - Clock port is clk; reset port is rst_n.
- Reset:
  - rst_n = 0 forces Q = 0 immediately, independent of clk.
  - Q stays 0 while rst_n is low, regardless of en, ldacc and D.
  - Deassertion is followed by normal operation from the next rising edge.
- Priority at each rising edge of clk, with rst_n = 1:
  - en = 0: Q holds its value. ldacc and D are ignored.
  - en = 1, ldacc = 1: Q <= D.
  - en = 1, ldacc = 0: Q <= (Q + D) mod 2^WIDTH.
- Arithmetic:
  - Unsigned addition, truncated to WIDTH bits.
  - Carry-out is discarded; the accumulator wraps around silently (e.g. 8'hFF + 8'h01 -> 8'h00).
  - No saturation and no overflow flag.
- Latency:
  - Q reflects a load or add one clock edge after inputs are sampled.
  - No combinational path from D, en or ldacc to Q.
- Inputs are sampled only at the rising edge; glitches between edges have no effect.
- Reset asserted mid-operation (including during a load or accumulate cycle) wins: Q = 0 with no pending update.
- Repeated loads with ldacc held at 1 keep Q = D every enabled edge. There is no accumulation while ldacc = 1.
- Q is never X after the first reset assertion.

Test Plan:
- Reset:
  - Stimulus: assert rst_n = 0 asynchronously between clock edges, with Q = 8'h2A.
  - Response: Q = 0 immediately, without waiting for a clock edge. Q stays 0 across edges while rst_n is low.
- Load then accumulate:
  - Stimulus: clk period 10 ns. en = 1, ldacc = 1, D = 1 for two edges, then ldacc = 0 with D = 1 held.
  - Response: Q = 1, 1, then 2, 3, 4, ... incrementing by 1 per edge (Q = 17 after 16 accumulate edges).
- Hold:
  - Stimulus: load D = 8'h55, then drive en = 0 while toggling ldacc and D = 8'hFF for 5 edges.
  - Response: Q stays 8'h55 throughout.
- Wrap-around:
  - Stimulus: load 8'hFE, then accumulate D = 8'h03.
  - Response: Q = 8'h01 after one edge. No error indication.
- Reload during accumulation:
  - Stimulus: accumulate to 8'h10, then ldacc = 1 with D = 8'hA0.
  - Response: Q = 8'hA0. Next accumulate with D = 8'h01 gives Q = 8'hA1.
- Reset mid-accumulate:
  - Stimulus: rst_n pulsed low for 3 ns while en = 1, ldacc = 0, D = 5.
  - Response: Q = 0 during the pulse. Next edge after release gives Q = 5.

Source files
------------

// File: rtl/accreg8bit.sv
// Clocked accumulator register: each enabled edge either loads D or adds D to
// the stored value, wrapping modulo 2^WIDTH. Q is purely registered.
module accreg8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D,
  input  logic             en,
  input  logic             ldacc,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;

  // Carry-out of the add is dropped on purpose: the accumulator wraps silently.
  always_comb begin
    acc_d = acc_q;
    if (en) begin
      if (ldacc) begin
        acc_d = D;
      end else begin
        acc_d = acc_q + D;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign Q = acc_q;

endmodule

// File: tb/tb_accreg8bit.sv
// Self-checking bench for accreg8bit: directed scenarios followed by random
// load/accumulate/hold traffic with occasional asynchronous reset pulses.
module tb_accreg8bit;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] D;
  logic         en;
  logic         ldacc;
  logic [W-1:0] Q;

  int n_checks = 0;
  int n_errors = 0;
  int model    = 0;
  logic [W-1:0] exp_q[$];

  accreg8bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .D     (D),
    .en    (en),
    .ldacc (ldacc),
    .Q     (Q)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic int ref_next(int cur, bit e, bit l, int d);
    if (!e) return cur;
    if (l)  return d;
    return (cur + d) % (1 << W);
  endfunction

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [W-1:0] obs,
                          input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; drives inputs, waits one edge, checks Q.
  task automatic step(input string tag, input bit e, input bit l,
                      input logic [W-1:0] d);
    logic [W-1:0] exp;
    en    = e;
    ldacc = l;
    D     = d;
    model = rst_n ? ref_next(model, e, l, int'(d)) : 0;
    exp_q.push_back(W'(model));
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check_eq(tag, Q, exp);
  endtask

  // Low pulse of 3 ns placed between edges; Q must clear without a clock.
  task automatic reset_pulse(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model = 0;
    check_eq(tag, Q, '0);
    #2;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    ldacc = 1'b0;
    D     = '0;
    #1;
    check_eq("reset_initial", Q, '0);
    @(posedge clk);
    #1;
    check_eq("reset_held", Q, '0);
    rst_n = 1'b1;

    // Async reset from a loaded value, then hold low across edges
    step("load_2a", 1, 1, 8'h2A);
    #2;
    rst_n = 1'b0;
    #1;
    model = 0;
    check_eq("async_reset", Q, '0);
    @(posedge clk);
    #1;
    step("reset_low_load", 1, 1, 8'hFF);
    step("reset_low_acc", 1, 0, 8'h11);
    rst_n = 1'b1;

    // Load then accumulate by 1
    step("load_1a", 1, 1, 8'h01);
    step("load_1b", 1, 1, 8'h01);
    for (int i = 0; i < 16; i++) step("acc_inc", 1, 0, 8'h01);
    check_eq("acc_17", Q, 8'd17);

    // Hold while disabled
    step("load_55", 1, 1, 8'h55);
    for (int i = 0; i < 5; i++) step("hold", 0, i[0], 8'hFF);
    check_eq("hold_55", Q, 8'h55);

    // Wrap-around
    step("load_fe", 1, 1, 8'hFE);
    step("wrap", 1, 0, 8'h03);
    check_eq("wrap_01", Q, 8'h01);
    step("load_ff", 1, 1, 8'hFF);
    step("wrap_ff_01", 1, 0, 8'h01);

    // Reload during accumulation
    step("load_08", 1, 1, 8'h08);
    step("acc_10", 1, 0, 8'h08);
    step("reload_a0", 1, 1, 8'hA0);
    step("acc_a1", 1, 0, 8'h01);
    check_eq("reload_a1", Q, 8'hA1);

    // Reset pulse mid-accumulate
    en = 1'b1; ldacc = 1'b0; D = 8'h05;
    reset_pulse("mid_acc_reset");
    step("after_reset_5", 1, 0, 8'h05);
    check_eq("after_reset_is_5", Q, 8'h05);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        reset_pulse("rand_reset");
      end
      step("rand", bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 3) == 0),
           W'($urandom_range(0, 255)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
